hex_display_ctrl: RTL and testbench

Parametrised, registered N-digit hexadecimal display controller for the board's seven-segment bank.
- Captures a data word on a load strobe and holds it until the next capture.
- Decodes each nibble to active-low segments.
- Optionally blanks leading zeros and blinks the whole display at a programmable rate.
- Sits between the processor's I/O register path and the HEX pins; successor to the fixed 8-digit combinational display.

---
 rtl/hex_display_ctrl.sv | 138 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Registered N-digit hexadecimal seven-segment controller with capture-on-load,
// leading-zero blanking and a programmable whole-display blink.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    hold,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    changed
);

    localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]      SEG_OFF  = 7'h7F;

    typedef enum logic {
        VISIBLE = 1'b0,
        DARK    = 1'b1
    } phase_t;

    logic [4*NUM_DIGITS-1:0] r_data;
    logic                    r_changed;
    logic [7*NUM_DIGITS-1:0] r_hexOut;
    logic [CNT_W-1:0]        r_count;
    phase_t                  r_phase;

    logic                    w_capture;
    logic [CNT_W-1:0]        w_countNext;
    phase_t                  w_phaseNext;
    logic                    w_dark;
    logic [7*NUM_DIGITS-1:0] w_hexNext;

    function automatic logic [6:0] decodeNibble(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // hold always wins over load, so a frozen display ignores the strobe entirely.
    assign w_capture = load & ~hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_capture && (data_in != r_data);
            if (w_capture) begin
                r_data <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= VISIBLE;
            r_count <= '0;
        end else begin
            r_phase <= w_phaseNext;
            r_count <= w_countNext;
        end
    end

    always_comb begin
        w_phaseNext = r_phase;
        w_countNext = r_count;
        if (!blink_en) begin
            w_phaseNext = VISIBLE;
            w_countNext = '0;
        end else if (r_count == CNT_LAST) begin
            w_countNext = '0;
            w_phaseNext = (r_phase == VISIBLE) ? DARK : VISIBLE;
        end else begin
            w_countNext = r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_dark = (r_phase == DARK);
    end

    // A digit above position 0 is a leading zero when it and every digit above it are zero.
    always_comb begin : hexDecode
        logic zeroAbove;
        w_hexNext = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zeroAbove = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (r_data[4*j +: 4] != 4'h0) begin
                    zeroAbove = 1'b0;
                end
            end
            if (w_dark) begin
                w_hexNext[7*i +: 7] = SEG_OFF;
            end else if (blank_lz && (i > 0) && zeroAbove) begin
                w_hexNext[7*i +: 7] = SEG_OFF;
            end else begin
                w_hexNext[7*i +: 7] = decodeNibble(r_data[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hexOut <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            r_hexOut <= w_hexNext;
        end
    end

    assign hex_out = r_hexOut;
    assign changed = r_changed;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with 8 digits and a short blink period.
module tb_hex_display_ctrl;

    localparam logic [55:0] ALL_OFF  = {8{7'h7F}};
    localparam logic [55:0] ALL_ZERO = {8{7'h40}};
    localparam logic [55:0] ALL_F    = {8{7'h0E}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic        hold = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [55:0] hex_out;
    logic        changed;

    int assertCount = 0;
    int failCount   = 0;

    hex_display_ctrl #(
        .NUM_DIGITS(8),
        .BLINK_DIV (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .load    (load),
        .hold    (hold),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .hex_out (hex_out),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL reset_hex: got %h expected %h", hex_out, ALL_OFF);
        end
        assertCount++;
        if (changed !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_changed: got %b expected 0", changed);
        end
        tick();
        tick();
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL reset_held_hex: got %h expected %h", hex_out, ALL_OFF);
        end
        reset = 1'b1;
        tick();
        assertCount++;
        if (hex_out !== ALL_ZERO) begin
            failCount++;
            $display("[TB] FAIL release_zeros: got %h expected %h", hex_out, ALL_ZERO);
        end
        assertCount++;
        if (changed !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL release_changed: got %b expected 0", changed);
        end
    endtask

    task automatic test_load();
        logic [55:0] expHex;
        expHex = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h0E};
        data_in = 32'h0123ABCF;
        load = 1'b1;
        tick();
        load = 1'b0;
        assertCount++;
        if (changed !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL load_changed_pulse: got %b expected 1", changed);
        end
        assertCount++;
        if (hex_out !== ALL_ZERO) begin
            failCount++;
            $display("[TB] FAIL load_latency: got %h expected %h", hex_out, ALL_ZERO);
        end
        tick();
        assertCount++;
        if (hex_out !== expHex) begin
            failCount++;
            $display("[TB] FAIL load_decode: got %h expected %h", hex_out, expHex);
        end
        assertCount++;
        if (changed !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL load_changed_end: got %b expected 0", changed);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        assertCount++;
        if (changed !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reload_same_changed: got %b expected 0", changed);
        end
        tick();
        assertCount++;
        if (hex_out !== expHex) begin
            failCount++;
            $display("[TB] FAIL reload_same_hex: got %h expected %h", hex_out, expHex);
        end
    endtask

    task automatic test_blank_lz();
        logic [55:0] expHex;
        blank_lz = 1'b1;
        data_in = 32'h00000A05;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        expHex = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12};
        assertCount++;
        if (hex_out !== expHex) begin
            failCount++;
            $display("[TB] FAIL blank_interior_zero: got %h expected %h", hex_out, expHex);
        end
        data_in = 32'h0;
        load = 1'b1;
        tick();
        load = 1'b0;
        assertCount++;
        if (changed !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL blank_zero_changed: got %b expected 1", changed);
        end
        tick();
        expHex = {{7{7'h7F}}, 7'h40};
        assertCount++;
        if (hex_out !== expHex) begin
            failCount++;
            $display("[TB] FAIL blank_all_zero: got %h expected %h", hex_out, expHex);
        end
        blank_lz = 1'b0;
        tick();
        assertCount++;
        if (hex_out !== ALL_ZERO) begin
            failCount++;
            $display("[TB] FAIL blank_off_zeros: got %h expected %h", hex_out, ALL_ZERO);
        end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        load = 1'b1;
        data_in = 32'hFFFFFFFF;
        tick();
        assertCount++;
        if (changed !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL hold_changed: got %b expected 0", changed);
        end
        tick();
        assertCount++;
        if (hex_out !== ALL_ZERO) begin
            failCount++;
            $display("[TB] FAIL hold_hex: got %h expected %h", hex_out, ALL_ZERO);
        end
        hold = 1'b0;
        tick();
        load = 1'b0;
        assertCount++;
        if (changed !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL unhold_changed: got %b expected 1", changed);
        end
        tick();
        assertCount++;
        if (hex_out !== ALL_F) begin
            failCount++;
            $display("[TB] FAIL unhold_hex: got %h expected %h", hex_out, ALL_F);
        end
    endtask

    task automatic test_blink();
        logic [55:0] expHex;
        blink_en = 1'b1;
        // The display goes dark for edges 5..8, 13..16, ... after enabling.
        for (int i = 1; i <= 14; i++) begin
            tick();
            expHex = ((((i - 1) / 4) % 2) == 1) ? ALL_OFF : ALL_F;
            assertCount++;
            if (hex_out !== expHex) begin
                failCount++;
                $display("[TB] FAIL blink_phase_%0d: got %h expected %h", i, hex_out, expHex);
            end
        end
        blink_en = 1'b0;
        tick();
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL blink_off_first_edge: got %h expected %h", hex_out, ALL_OFF);
        end
        tick();
        assertCount++;
        if (hex_out !== ALL_F) begin
            failCount++;
            $display("[TB] FAIL blink_off_visible: got %h expected %h", hex_out, ALL_F);
        end
    endtask

    task automatic test_load_during_dark();
        logic [55:0] expHex;
        expHex = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        blink_en = 1'b1;
        repeat (4) tick();
        assertCount++;
        if (hex_out !== ALL_F) begin
            failCount++;
            $display("[TB] FAIL restart_visible_4: got %h expected %h", hex_out, ALL_F);
        end
        tick();
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL restart_dark_5: got %h expected %h", hex_out, ALL_OFF);
        end
        data_in = 32'h12345678;
        load = 1'b1;
        tick();
        load = 1'b0;
        assertCount++;
        if (changed !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL dark_load_changed: got %b expected 1", changed);
        end
        tick();
        tick();
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL dark_load_hidden: got %h expected %h", hex_out, ALL_OFF);
        end
        tick();
        assertCount++;
        if (hex_out !== expHex) begin
            failCount++;
            $display("[TB] FAIL dark_load_shown: got %h expected %h", hex_out, expHex);
        end
    endtask

    task automatic test_async_reset();
        data_in = 32'hFFFF0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        #2 reset = 1'b0;
        #1;
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL async_reset_hex: got %h expected %h", hex_out, ALL_OFF);
        end
        assertCount++;
        if (changed !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset_changed: got %b expected 0", changed);
        end
        tick();
        reset = 1'b1;
        tick();
        assertCount++;
        if (hex_out !== ALL_ZERO) begin
            failCount++;
            $display("[TB] FAIL post_reset_zeros: got %h expected %h", hex_out, ALL_ZERO);
        end
        repeat (3) tick();
        assertCount++;
        if (hex_out !== ALL_ZERO) begin
            failCount++;
            $display("[TB] FAIL post_reset_visible_4: got %h expected %h", hex_out, ALL_ZERO);
        end
        tick();
        assertCount++;
        if (hex_out !== ALL_OFF) begin
            failCount++;
            $display("[TB] FAIL post_reset_dark_5: got %h expected %h", hex_out, ALL_OFF);
        end
        blink_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank_lz();
        test_hold();
        test_blink();
        test_load_during_dark();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
